// File: rtl/count_wrap_monitor_if.sv
`default_nettype none
// ----------------------------------------------------------------------------
// count_wrap_monitor_if
// Bundles the sampled counter bus (en/clr/count) with the monitor's results.
// master: the side that drives the counter bus; slave: the monitor.
// Revision: 1.0  initial release
// ----------------------------------------------------------------------------
interface count_wrap_monitor_if #(
  parameter int HI_WIDTH = 8
);
  logic                  en;
  logic                  clr;
  logic [7:0]            count;
  logic [HI_WIDTH+7:0]   ext_count;
  logic                  ovf_pulse;
  logic                  unf_pulse;
  logic                  jump_pulse;
  logic                  dir;
  logic                  hi_err;

  modport master (
    output en, clr, count,
    input  ext_count, ovf_pulse, unf_pulse, jump_pulse, dir, hi_err
  );

  modport slave (
    input  en, clr, count,
    output ext_count, ovf_pulse, unf_pulse, jump_pulse, dir, hi_err
  );
endinterface
`default_nettype wire

// File: rtl/count_wrap_monitor.sv
`default_nettype none
// ----------------------------------------------------------------------------
// count_wrap_monitor
// Watches an 8-bit up/down counter, classifies every enabled step and
// extends the count with a wrapping upper field {hi, last}.
// Revision: 1.0  initial release
// ----------------------------------------------------------------------------
module count_wrap_monitor #(
  parameter int HI_WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst,    // asynchronous, active-low
  count_wrap_monitor_if.slave  bus
);

  typedef enum logic [0:0] {
    INIT  = 1'b0,
    TRACK = 1'b1
  } state_t;

  state_t                state, state_nxt;
  logic [HI_WIDTH-1:0]   hi, hi_nxt;
  logic [7:0]            last, last_nxt;
  logic                  dir, dir_nxt;
  logic                  hi_err, hi_err_nxt;
  logic                  ovf, ovf_nxt;
  logic                  unf, unf_nxt;
  logic                  jump, jump_nxt;

  // Neighbours of the previous sample, kept 8 bits wide so they wrap.
  logic [7:0]            last_inc;
  logic [7:0]            last_dec;
  assign last_inc = last + 8'd1;
  assign last_dec = last - 8'd1;

  // Register all state and the one-cycle event pulses.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state  <= INIT;
      hi     <= '0;
      last   <= '0;
      dir    <= 1'b1;
      hi_err <= 1'b0;
      ovf    <= 1'b0;
      unf    <= 1'b0;
      jump   <= 1'b0;
    end else begin
      state  <= state_nxt;
      hi     <= hi_nxt;
      last   <= last_nxt;
      dir    <= dir_nxt;
      hi_err <= hi_err_nxt;
      ovf    <= ovf_nxt;
      unf    <= unf_nxt;
      jump   <= jump_nxt;
    end
  end

  // Step classification; wrap cases are tested before the +/-1 cases so a
  // 255->0 step is an overflow rather than a plain up step.
  always_comb begin
    state_nxt  = state;
    hi_nxt     = hi;
    last_nxt   = last;
    dir_nxt    = dir;
    hi_err_nxt = hi_err;
    ovf_nxt    = 1'b0;
    unf_nxt    = 1'b0;
    jump_nxt   = 1'b0;

    if (bus.clr) begin
      state_nxt  = INIT;
      hi_nxt     = '0;
      last_nxt   = '0;
      dir_nxt    = 1'b1;
      hi_err_nxt = 1'b0;
    end else if (bus.en) begin
      last_nxt = bus.count;
      case (state)
        INIT: begin
          hi_nxt    = '0;
          state_nxt = TRACK;
        end
        TRACK: begin
          if (last == 8'hFF && bus.count == 8'h00) begin
            hi_nxt  = hi + 1'b1;
            ovf_nxt = 1'b1;
            dir_nxt = 1'b1;
            if (&hi) begin
              hi_err_nxt = 1'b1;
            end
          end else if (last == 8'h00 && bus.count == 8'hFF) begin
            hi_nxt  = hi - 1'b1;
            unf_nxt = 1'b1;
            dir_nxt = 1'b0;
            if (hi == '0) begin
              hi_err_nxt = 1'b1;
            end
          end else if (bus.count == last_inc) begin
            dir_nxt = 1'b1;
          end else if (bus.count == last_dec) begin
            dir_nxt = 1'b0;
          end else if (bus.count == last) begin
            dir_nxt = dir;   // stall: nothing moves
          end else begin
            hi_nxt   = '0;
            jump_nxt = 1'b1;
          end
        end
        default: begin
          state_nxt = INIT;
        end
      endcase
    end
  end

  assign bus.ext_count  = {hi, last};
  assign bus.ovf_pulse  = ovf;
  assign bus.unf_pulse  = unf;
  assign bus.jump_pulse = jump;
  assign bus.dir        = dir;
  assign bus.hi_err     = hi_err;

endmodule
`default_nettype wire

// File: tb/tb_count_wrap_monitor.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_count_wrap_monitor
// Directed bench: one monitor at the default upper width, one at width 2,
// both fed the same counter stream.
// Revision: 1.0  initial release
// ----------------------------------------------------------------------------
module tb_count_wrap_monitor;

  logic       clk;
  logic       rst;
  logic       en;
  logic       clr;
  logic [7:0] count;

  int vectors     = 0;
  int miscompares = 0;

  count_wrap_monitor_if #(.HI_WIDTH(8)) b8 ();
  count_wrap_monitor_if #(.HI_WIDTH(2)) b2 ();

  assign b8.en = en;  assign b8.clr = clr;  assign b8.count = count;
  assign b2.en = en;  assign b2.clr = clr;  assign b2.count = count;

  count_wrap_monitor #(.HI_WIDTH(8)) dut8 (.clk(clk), .rst(rst), .bus(b8));
  count_wrap_monitor #(.HI_WIDTH(2)) dut2 (.clk(clk), .rst(rst), .bus(b2));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Drive one sample, then settle just after the capturing edge.
  task automatic step(input logic e, input logic c, input logic [7:0] v);
    en = e; clr = c; count = v;
    @(posedge clk);
    #1;
  endtask

  // Full output check of the width-8 monitor; p = {ovf, unf, jump}.
  task automatic exp8(input string tag, input logic [15:0] ext, input logic [2:0] p,
                      input logic d, input logic err);
    chk({tag, ".ext"},   {16'h0, b8.ext_count}, {16'h0, ext});
    chk({tag, ".pulse"}, {29'h0, b8.ovf_pulse, b8.unf_pulse, b8.jump_pulse}, {29'h0, p});
    chk({tag, ".dir"},   {31'h0, b8.dir},    {31'h0, d});
    chk({tag, ".err"},   {31'h0, b8.hi_err}, {31'h0, err});
  endtask

  task automatic exp2(input string tag, input logic [9:0] ext, input logic ovf,
                      input logic err);
    chk({tag, ".ext2"}, {22'h0, b2.ext_count}, {22'h0, ext});
    chk({tag, ".ovf2"}, {31'h0, b2.ovf_pulse}, {31'h0, ovf});
    chk({tag, ".err2"}, {31'h0, b2.hi_err},    {31'h0, err});
  endtask

  initial begin
    rst = 1'b0; en = 1'b0; clr = 1'b0; count = 8'h00;
    repeat (3) @(posedge clk);
    #1;
    exp8("reset", 16'h0000, 3'b000, 1'b1, 1'b0);
    exp2("reset", 10'h000, 1'b0, 1'b0);
    rst = 1'b1;

    // Load 250 and count up across the 255->0 wrap.
    step(1, 0, 8'd250); exp8("up_init", 16'h00FA, 3'b000, 1'b1, 1'b0);
    for (int v = 251; v <= 255; v++) begin
      step(1, 0, 8'(v)); exp8("up_step", 16'(v), 3'b000, 1'b1, 1'b0);
    end
    step(1, 0, 8'd0);   exp8("ovf",   16'h0100, 3'b100, 1'b1, 1'b0);
    step(1, 0, 8'd1);   exp8("ovf+1", 16'h0101, 3'b000, 1'b1, 1'b0);
    step(1, 0, 8'd2);   exp8("ovf+2", 16'h0102, 3'b000, 1'b1, 1'b0);

    // Fresh start, load 2 and count down across 0->255 with hi at zero.
    step(1, 1, 8'd77);  exp8("clr_a", 16'h0000, 3'b000, 1'b1, 1'b0);
    step(1, 0, 8'd2);   exp8("dn_init", 16'h0002, 3'b000, 1'b1, 1'b0);
    step(1, 0, 8'd1);   exp8("dn1",   16'h0001, 3'b000, 1'b0, 1'b0);
    step(1, 0, 8'd0);   exp8("dn0",   16'h0000, 3'b000, 1'b0, 1'b0);
    step(1, 0, 8'd255); exp8("unf",   16'hFFFF, 3'b010, 1'b0, 1'b1);
    step(1, 0, 8'd254); exp8("unf+1", 16'hFFFE, 3'b000, 1'b0, 1'b1);
    step(1, 0, 8'd253); exp8("unf+2", 16'hFFFD, 3'b000, 1'b0, 1'b1);

    // Reach 0x0140 counting up, then a load to 0x80 is a jump.
    step(1, 1, 8'd0);   exp8("clr_b", 16'h0000, 3'b000, 1'b1, 1'b0);
    step(1, 0, 8'hFF);
    step(1, 0, 8'h00);  exp8("ovf_b", 16'h0100, 3'b100, 1'b1, 1'b0);
    for (int v = 1; v <= 8'h40; v++) step(1, 0, 8'(v));
    exp8("at140", 16'h0140, 3'b000, 1'b1, 1'b0);
    step(1, 0, 8'h80);  exp8("jump",  16'h0080, 3'b001, 1'b1, 1'b0);
    step(1, 0, 8'h81);  exp8("jmp+1", 16'h0081, 3'b000, 1'b1, 1'b0);
    step(1, 0, 8'h82);  exp8("jmp+2", 16'h0082, 3'b000, 1'b1, 1'b0);

    // Narrow upper field: four overflows walk hi 1,2,3,0 and set hi_err.
    step(1, 1, 8'd0);   exp2("clr_c", 10'h000, 1'b0, 1'b0);
    step(1, 0, 8'hFF);  exp2("w2_init", 10'h0FF, 1'b0, 1'b0);
    for (int k = 1; k <= 4; k++) begin
      step(1, 0, 8'h00);
      exp2($sformatf("w2_ovf%0d", k), {2'(k), 8'h00}, 1'b1, (k == 4));
      if (k < 4) for (int v = 1; v <= 255; v++) step(1, 0, 8'(v));
    end
    step(1, 0, 8'd1);   exp2("w2_hold1", 10'h001, 1'b0, 1'b1);
    step(1, 0, 8'd2);   exp2("w2_hold2", 10'h002, 1'b0, 1'b1);
    step(1, 1, 8'd3);   exp2("w2_clr",   10'h000, 1'b0, 1'b0);

    // Enable gap while the counter moves 10->13, then clr beats en.
    step(1, 1, 8'd0);
    step(1, 0, 8'd10);  exp8("gap_init", 16'h000A, 3'b000, 1'b1, 1'b0);
    for (int v = 11; v <= 13; v++) begin
      step(0, 0, 8'(v)); exp8("gap_hold", 16'h000A, 3'b000, 1'b1, 1'b0);
    end
    step(1, 0, 8'd13);  exp8("gap_jump", 16'h000D, 3'b001, 1'b1, 1'b0);
    step(1, 1, 8'd14);  exp8("clr_en",   16'h0000, 3'b000, 1'b1, 1'b0);
    step(1, 0, 8'd20);  exp8("clr_init", 16'h0014, 3'b000, 1'b1, 1'b0);

    // Build hi=3, then assert reset between edges.
    step(1, 1, 8'd0);
    step(1, 0, 8'hFF);
    for (int k = 1; k <= 3; k++) begin
      step(1, 0, 8'h00);
      if (k < 3) for (int v = 1; v <= 255; v++) step(1, 0, 8'(v));
    end
    exp8("hi3", 16'h0300, 3'b100, 1'b1, 1'b0);
    #2 rst = 1'b0;
    #1 exp8("async_rst", 16'h0000, 3'b000, 1'b1, 1'b0);
    @(posedge clk);
    #1 rst = 1'b1;
    step(1, 0, 8'hFF);  exp8("rst_init", 16'h00FF, 3'b000, 1'b1, 1'b0);
    step(1, 0, 8'h00);  exp8("rst_ovf",  16'h0100, 3'b100, 1'b1, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/count_wrap_monitor.md
# count_wrap_monitor

Downstream monitor for the 8-bit up/down counter. Samples the counter's `count` output every enabled cycle and classifies each step as up, down, stall, overflow wrap (255→0), underflow wrap (0→255) or jump (load or any other discontinuity). Extends the 8-bit count with a signed-wrap upper field into a wider extended count, emits one-cycle event pulses, and keeps a sticky error flag for upper-field wrap.

## Interface
- `HI_WIDTH`, default 8: width of the upper extension field; `ext_count` is `HI_WIDTH+8` bits.

Ports:
- `clk`  in  1  rising-edge clock, shared with the counter.
- `rst`  in  1  asynchronous, active-low reset.
- `en`  in  1  sample enable; when low, `count` is ignored and all state holds.
- `clr`  in  1  synchronous clear back to INIT.
- `count`  in  8  counter output, sampled on the rising edge of `clk`.
- `ext_count`  out  HI_WIDTH+8  `{hi, last}`: extended count of the last accepted sample.
- `ovf_pulse`  out  1  one-cycle pulse on a 255→0 step.
- `unf_pulse`  out  1  one-cycle pulse on a 0→255 step.
- `jump_pulse`  out  1  one-cycle pulse on a discontinuous step.
- `dir`  out  1  last observed direction: 1 = up, 0 = down.
- `hi_err`  out  1  sticky flag: `hi` wrapped modulo 2^HI_WIDTH.

## Operation
- Two states:
  - INIT: no previous sample is held.
  - TRACK: `last` holds the previous sample.
- Reset (async, `rst`=0): state INIT; `hi`=0, `last`=0, `ext_count`=0, all pulses 0, `dir`=1, `hi_err`=0.
- `clr`=1 at an edge: same values as reset, applied synchronously. `clr` has priority over `en`.
- `en`=0 (and `clr`=0): state, `hi`, `last`, `dir` and `hi_err` hold; all pulses are 0 that cycle.
- INIT with `en`=1:
  - `last`←`count`, `hi`←0.
  - No pulse is raised; `dir` is unchanged.
  - Next state TRACK.
- TRACK with `en`=1: classify `count` against `last` in this priority order:
  1. `last`=255, `count`=0 (overflow): `hi`←`hi`+1; `ovf_pulse`=1; `dir`←1.
  2. `last`=0, `count`=255 (underflow): `hi`←`hi`−1; `unf_pulse`=1; `dir`←0.
  3. `count`=`last`+1 (up): `dir`←1; `hi` unchanged.
  4. `count`=`last`−1 (down): `dir`←0; `hi` unchanged.
  5. `count`=`last` (stall): no change to `hi` or `dir`; no pulse.
  6. Anything else (jump): `hi`←0; `jump_pulse`=1; `dir` unchanged.
  - In every case, `last`←`count`.
- Upper-field arithmetic is modulo 2^HI_WIDTH:
  - Overflow while `hi` = all-ones: `hi`←0 and `hi_err`←1.
  - Underflow while `hi`=0: `hi`←all-ones and `hi_err`←1.
  - `hi_err` clears only on reset or `clr`.
- At most one of `ovf_pulse`, `unf_pulse`, `jump_pulse` is high in any cycle.

## Timing
- All outputs are registered.
- A `count` value sampled at edge N appears in `ext_count` after edge N; its pulse is high for exactly the cycle between edges N and N+1.
- End-to-end latency from counter state to monitor outputs is 1 cycle. Counter load → `jump_pulse` is 2 edges: the counter updates at edge N and the monitor classifies at edge N+1.
- `dir` and `hi_err` update at the same edge as the pulses.
- Reset asserted mid-operation clears all outputs immediately, without waiting for a clock edge. After release, the first enabled sample is INIT, with no pulse.
- `clr` and `en` both high: `clr` wins, and that cycle's sample is discarded.

## Test plan
- Reset, then counter loaded 250 and counting up for 10 cycles → first sample no pulse; `ovf_pulse` exactly once on the 255→0 step; `ext_count` goes 0x00FF→0x0100; `dir`=1.
- Counter loaded 2 and counting down for 5 cycles → `unf_pulse` once on 0→255; `ext_count`=0xFFFF (`hi`=0xFF); `hi_err`=1; `dir`=0.
- Counting up at 0x0140, then counter load 0x80 → `jump_pulse` once; `ext_count`=0x0080; `dir` stays 1; subsequent up steps give no pulse.
- `HI_WIDTH`=2, 4 overflows from 0 → `hi` sequence 1,2,3,0; `hi_err` set on the 4th and held through later clean steps until `clr`.
- `en` low for 3 cycles while the counter moves 10→13, then high → state held during the gap; the 10→13 step classifies as a jump. Next, `clr`=1 with `en`=1 → outputs 0, state INIT, no pulse.
- `rst` asserted between edges while TRACK with `hi`=3 → all outputs 0 immediately; after release, `count`=255 then 0 → the first sample has no pulse, the second gives `ovf_pulse` and `ext_count`=0x0100.
